// File: rtl/serial_sub_5b_if.sv
// Start/busy/done operand and result bundle for the bit-serial subtractor.
// The requester drives the operands and start. The subtractor returns busy, done and the result.
// With SUB_OVF_EN defined, the bundle also carries the signed overflow flag ovf.
interface serial_sub_5b_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (output start, A, B, Bin, input busy, done, D, Bout, ovf);
    modport slave  (input start, A, B, Bin, output busy, done, D, Bout, ovf);
`else
    modport master (output start, A, B, Bin, input busy, done, D, Bout);
    modport slave  (input start, A, B, Bin, output busy, done, D, Bout);
`endif
endinterface

// File: rtl/serial_sub_5b.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, with signed overflow under SUB_OVF_EN.
// Latency: done pulses in the cycle after the WIDTH-th SHIFT edge that follows an accepted start.
// Backpressure: start is sampled only in IDLE; while busy it is ignored and nothing is queued.
module serial_sub_5b #(
    parameter int WIDTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    serial_sub_5b_if.slave sb
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_reg;
`endif

    // State register; reset always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start leaves IDLE, the final bit edge enters DONE, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sb.start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        sb.busy = 1'b0;
        sb.done = 1'b0;
        case (state)
            SHIFT:   sb.busy = 1'b1;
            DONE: begin
                sb.busy = 1'b1;
                sb.done = 1'b1;
            end
            default: ;
        endcase
    end

    // One full-subtractor bit slice working on the current LSBs and the borrow register.
    always_comb begin
        a_bit    = a_sh[0];
        b_bit    = b_sh[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        last_bit = (state == SHIFT) && (cnt == LAST);
    end

    // Datapath: capture operands on an accepted start, then shift one bit per SHIFT edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            br       <= 1'b0;
            d_reg    <= '0;
            bout_reg <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_reg  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (sb.start) begin
                a_sh  <= sb.A;
                b_sh  <= sb.B;
                br    <= sb.Bin;
                cnt   <= '0;
                d_reg <= '0;
`ifdef SUB_OVF_EN
                a_msb <= sb.A[WIDTH-1];
                b_msb <= sb.B[WIDTH-1];
`endif
            end
        end else if (state == SHIFT) begin
            // Difference bits arrive LSB first, so each new bit enters at the MSB end.
            d_reg <= {d_bit, d_reg[WIDTH-1:1]};
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            br    <= br_nxt;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                bout_reg <= br_nxt;
`ifdef SUB_OVF_EN
                // Overflow only when operand signs differ and the result sign departs from A.
                ovf_reg  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
            end
        end
    end

    assign sb.D    = d_reg;
    assign sb.Bout = bout_reg;
`ifdef SUB_OVF_EN
    assign sb.ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_sub_5b.sv
// Self-checking bench for serial_sub_5b, covering spec vectors, busy/done timing, ignored start, reset abort and back-to-back operation.
// Random operations are checked against an integer-arithmetic reference model.
// With SUB_OVF_EN defined, the bench also checks the signed overflow flag.
module tb_serial_sub_5b;
    localparam int W = 5;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    serial_sub_5b_if #(.WIDTH(W)) bus ();

    serial_sub_5b #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction, unsigned borrow, signed range test.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int diff;
        int sa;
        int sbv;
        int sres;
        diff = int'(a) - int'(b) - int'(bin);
        d    = W'(diff);
        bo   = (diff < 0);
        sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sbv  = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sres = sa - sbv - int'(bin);
        ov   = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
    endfunction

    // Runs one operation from IDLE and returns the latency in edges after the start edge, plus the result.
    // The task leaves the DUT back in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat, output logic [W-1:0] d, output logic bo, output logic ov);
        bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        d = '0; bo = 1'b0; ov = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        d  = bus.D;
        bo = bus.Bout;
`ifdef SUB_OVF_EN
        ov = bus.ovf;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
        checks++; if (bus.D !== '0) $display("FAIL reset_D got=%b exp=00000", bus.D); else passed++;
        checks++; if (bus.Bout !== 1'b0) $display("FAIL reset_Bout got=%b exp=0", bus.Bout); else passed++;
`ifdef SUB_OVF_EN
        checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.ovf); else passed++;
`endif
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vbin [4];
        logic [W-1:0] vd [4];
        logic         vbo [4];
        int lat;
        logic [W-1:0] d, ed;
        logic bo, ebo, ov, eov;
        va[0] = 5'b10001; vb[0] = 5'b10101; vbin[0] = 1'b0; vd[0] = 5'b11100; vbo[0] = 1'b1;
        va[1] = 5'b10110; vb[1] = 5'b10000; vbin[1] = 1'b0; vd[1] = 5'b00110; vbo[1] = 1'b0;
        va[2] = 5'b01010; vb[2] = 5'b11111; vbin[2] = 1'b1; vd[2] = 5'b01010; vbo[2] = 1'b1;
        va[3] = 5'b10110; vb[3] = 5'b10110; vbin[3] = 1'b0; vd[3] = 5'b00000; vbo[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vbin[i], lat, d, bo, ov);
            model(va[i], vb[i], vbin[i], ed, ebo, eov);
            checks++; if (lat !== W) $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, W); else passed++;
            checks++; if (d !== vd[i] || d !== ed) $display("FAIL vec%0d_D got=%b exp=%b", i, d, vd[i]); else passed++;
            checks++; if (bo !== vbo[i] || bo !== ebo) $display("FAIL vec%0d_Bout got=%b exp=%b", i, bo, vbo[i]); else passed++;
        end
    endtask

    task automatic test_busy();
        int busy_cnt;
        int done_cnt;
        bus.A = 5'b10110; bus.B = 5'b10000; bus.Bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        checks++; if (busy_cnt !== W + 1) $display("FAIL busy_cycles got=%0d exp=%0d", busy_cnt, W + 1); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL busy_done_pulses got=%0d exp=1", done_cnt); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL busy_idle got=%b exp=0", bus.busy); else passed++;
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        logic [W-1:0] d;
        logic bo;
        bus.A = 5'b10001; bus.B = 5'b10101; bus.Bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.A = 5'b00001; bus.B = 5'b01000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_cnt = 0; d = '0; bo = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                d = bus.D;
                bo = bus.Bout;
            end
            @(posedge clk); #1;
        end
        checks++; if (done_cnt !== 1) $display("FAIL ignore_done_pulses got=%0d exp=1", done_cnt); else passed++;
        checks++; if (d !== 5'b11100) $display("FAIL ignore_D got=%b exp=11100", d); else passed++;
        checks++; if (bo !== 1'b1) $display("FAIL ignore_Bout got=%b exp=1", bo); else passed++;
        checks++; if (bus.D !== 5'b11100) $display("FAIL ignore_hold_D got=%b exp=11100", bus.D); else passed++;
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        int lat;
        logic [W-1:0] d;
        logic bo, ov;
        bus.A = 5'b10001; bus.B = 5'b10101; bus.Bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", bus.done); else passed++;
        checks++; if (bus.D !== '0) $display("FAIL abort_D got=%b exp=00000", bus.D); else passed++;
        checks++; if (bus.Bout !== 1'b0) $display("FAIL abort_Bout got=%b exp=0", bus.Bout); else passed++;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        checks++; if (done_cnt !== 0) $display("FAIL abort_stray_done got=%0d exp=0", done_cnt); else passed++;
        run_op(5'b01011, 5'b00001, 1'b0, lat, d, bo, ov);
        checks++; if (lat !== W) $display("FAIL abort_fresh_latency got=%0d exp=%0d", lat, W); else passed++;
        checks++; if (d !== 5'b01010) $display("FAIL abort_fresh_D got=%b exp=01010", d); else passed++;
        checks++; if (bo !== 1'b0) $display("FAIL abort_fresh_Bout got=%b exp=0", bo); else passed++;
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] a, b, d, ed;
        logic bin, bo, ebo, ov, eov;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom_range(0, 1));
            run_op(a, b, bin, lat, d, bo, ov);
            model(a, b, bin, ed, ebo, eov);
            checks++; if (lat !== W || d !== ed || bo !== ebo)
                $display("FAIL rand_op a=%b b=%b bin=%b got lat=%0d D=%b Bout=%b exp lat=%0d D=%b Bout=%b",
                         a, b, bin, lat, d, bo, W, ed, ebo);
            else passed++;
`ifdef SUB_OVF_EN
            checks++; if (ov !== eov) $display("FAIL rand_ovf a=%b b=%b bin=%b got=%b exp=%b", a, b, bin, ov, eov);
            else passed++;
`endif
        end
    endtask

    task automatic test_back_to_back();
        int first_at, second_at;
        logic [W-1:0] d1, d2, e1, e2;
        logic bo1, bo2, eb1, eb2, ov;
        logic [W-1:0] a1, b1, a2, b2;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        model(a1, b1, 1'b0, e1, eb1, ov);
        model(a2, b2, 1'b1, e2, eb2, ov);
        bus.A = a1; bus.B = b1; bus.Bin = 1'b0; bus.start = 1'b1;
        first_at = -1; second_at = -1;
        d1 = '0; d2 = '0; bo1 = 1'b0; bo2 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                if (first_at < 0) begin
                    first_at = i; d1 = bus.D; bo1 = bus.Bout;
                    bus.A = a2; bus.B = b2; bus.Bin = 1'b1;
                end else begin
                    second_at = i; d2 = bus.D; bo2 = bus.Bout;
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        checks++; if (first_at !== W + 1) $display("FAIL b2b_first_done got=%0d exp=%0d", first_at, W + 1); else passed++;
        checks++; if (second_at !== 2 * W + 3) $display("FAIL b2b_second_done got=%0d exp=%0d", second_at, 2 * W + 3); else passed++;
        checks++; if (d1 !== e1 || bo1 !== eb1) $display("FAIL b2b_op1 got=%b/%b exp=%b/%b", d1, bo1, e1, eb1); else passed++;
        checks++; if (d2 !== e2 || bo2 !== eb2) $display("FAIL b2b_op2 got=%b/%b exp=%b/%b", d2, bo2, e2, eb2); else passed++;
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        int lat;
        logic [W-1:0] d;
        logic bo, ov;
        run_op(5'b01111, 5'b11110, 1'b0, lat, d, bo, ov);
        checks++; if (d !== 5'b10001 || bo !== 1'b1 || ov !== 1'b1)
            $display("FAIL ovf_case1 got=%b/%b/%b exp=10001/1/1", d, bo, ov); else passed++;
        run_op(5'b01001, 5'b01011, 1'b0, lat, d, bo, ov);
        checks++; if (d !== 5'b11110 || bo !== 1'b1 || ov !== 1'b0)
            $display("FAIL ovf_case2 got=%b/%b/%b exp=11110/1/0", d, bo, ov); else passed++;
    endtask
`endif

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_vectors();
        test_busy();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_back_to_back();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
